// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the debouncer/display side and the stopwatch controller.
// The master side drives the debounced buttons and preset; the slave side drives the count and status.
interface stopwatch_ctrl_if;
  logic        start_db;
  logic        stop_db;
  logic        load_db;
  logic        reset_btn_db;
  logic [15:0] load_value;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        running;
  logic        rollover;
  logic        load_err;

  modport master (
    output start_db, stop_db, load_db, reset_btn_db, load_value,
    input  digits, state, running, rollover, load_err
  );

  modport slave (
    input  start_db, stop_db, load_db, reset_btn_db, load_value,
    output digits, state, running, rollover, load_err
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge events, run/pause FSM, prescaler and 4-digit BCD MM:SS counter.
// All outputs are registered; events sampled on edge k are visible after edge k.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [15:0]   r_digits;
  logic [15:0]   w_nextDigits;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_nextPresc;
  logic          r_rollover;
  logic          w_nextRollover;
  logic          r_loadErr;
  logic          w_nextLoadErr;
  logic          r_running;

  logic          r_prevStart;
  logic          r_prevStop;
  logic          r_prevLoad;
  logic          r_prevResetBtn;

  logic          w_evStart;
  logic          w_evStop;
  logic          w_evLoad;
  logic          w_evResetBtn;
  logic          w_tick;
  logic          w_loadValid;
  logic [16:0]   w_incDigits;

  // Ripple-carry BCD increment; bit 16 flags the 99:59 -> 00:00 wrap.
  function automatic logic [16:0] bcdInc(input logic [15:0] d);
    logic [3:0] secOnes;
    logic [3:0] secTens;
    logic [3:0] minOnes;
    logic [3:0] minTens;
    logic       wrap;
    secOnes = d[3:0];
    secTens = d[7:4];
    minOnes = d[11:8];
    minTens = d[15:12];
    wrap    = 1'b0;
    if (secOnes != 4'd9) begin
      secOnes = secOnes + 4'd1;
    end else begin
      secOnes = 4'd0;
      if (secTens != 4'd5) begin
        secTens = secTens + 4'd1;
      end else begin
        secTens = 4'd0;
        if (minOnes != 4'd9) begin
          minOnes = minOnes + 4'd1;
        end else begin
          minOnes = 4'd0;
          if (minTens != 4'd9) begin
            minTens = minTens + 4'd1;
          end else begin
            minTens = 4'd0;
            wrap    = 1'b1;
          end
        end
      end
    end
    return {wrap, minTens, minOnes, secTens, secOnes};
  endfunction

  assign w_evStart    = sw.start_db     & ~r_prevStart;
  assign w_evStop     = sw.stop_db      & ~r_prevStop;
  assign w_evLoad     = sw.load_db      & ~r_prevLoad;
  assign w_evResetBtn = sw.reset_btn_db & ~r_prevResetBtn;

  assign w_tick      = (r_state == RUN) && (r_presc == TICK_LAST);
  assign w_incDigits = bcdInc(r_digits);
  assign w_loadValid = (sw.load_value[15:12] <= 4'd9) && (sw.load_value[11:8] <= 4'd9) &&
                       (sw.load_value[7:4]   <= 4'd5) && (sw.load_value[3:0]  <= 4'd9);

  // History regs reset high so a button held through reset yields no event.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_prevStart    <= 1'b1;
      r_prevStop     <= 1'b1;
      r_prevLoad     <= 1'b1;
      r_prevResetBtn <= 1'b1;
    end else begin
      r_prevStart    <= sw.start_db;
      r_prevStop     <= sw.stop_db;
      r_prevLoad     <= sw.load_db;
      r_prevResetBtn <= sw.reset_btn_db;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_digits   <= '0;
      r_presc    <= '0;
      r_rollover <= 1'b0;
      r_loadErr  <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_digits   <= w_nextDigits;
      r_presc    <= w_nextPresc;
      r_rollover <= w_nextRollover;
      r_loadErr  <= w_nextLoadErr;
      r_running  <= (w_nextState == RUN);
    end
  end

  // In RUN a tick coinciding with stop still counts before pausing.
  always_comb begin
    w_nextState    = r_state;
    w_nextDigits   = r_digits;
    w_nextPresc    = r_presc;
    w_nextRollover = 1'b0;
    w_nextLoadErr  = 1'b0;
    if (w_evResetBtn) begin
      w_nextState  = IDLE;
      w_nextDigits = '0;
      w_nextPresc  = '0;
    end else begin
      case (r_state)
        RUN: begin
          w_nextPresc = w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            w_nextDigits   = w_incDigits[15:0];
            w_nextRollover = w_incDigits[16];
          end
          if (w_evStop) begin
            w_nextState = PAUSE;
          end
        end
        IDLE, PAUSE: begin
          if (w_evLoad) begin
            if (w_loadValid) begin
              w_nextDigits = sw.load_value;
              w_nextPresc  = '0;
              w_nextState  = PAUSE;
            end else begin
              w_nextLoadErr = 1'b1;
            end
          end else if (w_evStart) begin
            w_nextState = RUN;
          end
        end
        default: begin
          w_nextState  = IDLE;
          w_nextDigits = '0;
          w_nextPresc  = '0;
        end
      endcase
    end
  end

  assign sw.digits   = r_digits;
  assign sw.state    = r_state;
  assign sw.running  = r_running;
  assign sw.rollover = r_rollover;
  assign sw.load_err = r_loadErr;

endmodule
